// File: rtl/ucc_monitor.sv
// ucc_monitor
// Runtime isolation monitor for up to three untrusted code compartments.
// It watches the program counter, CPU data bus and DMA bus every cycle and
// tracks which compartment is executing. Any isolation breach raises a
// sticky violation flag, which drives the core reset. The flag is held until
// the CPU fetches from the reset handler.
//
// Ports:
//   clk, reset             system clock; synchronous active-high reset
//   pc                     current program counter
//   irq                    interrupt taken this cycle
//   data_en/data_wr/addr   CPU data access strobe, write qualifier, address
//   dma_en/dma_addr        DMA access strobe and address
//   ucc_min_n/ucc_max_n    static bounds of compartment n (n = 0..2);
//                          a region is disabled when min > max
//   violation              isolation violation (KILL state)
//   in_ucc                 execution is inside a compartment
//   ucc_id                 active compartment index; 2'b11 when outside
module ucc_monitor #(
    parameter logic [15:0] RESET_PC = 16'hE000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        irq,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic        dma_en,
    input  logic [15:0] dma_addr,
    input  logic [15:0] ucc_min_0,
    input  logic [15:0] ucc_max_0,
    input  logic [15:0] ucc_min_1,
    input  logic [15:0] ucc_max_1,
    input  logic [15:0] ucc_min_2,
    input  logic [15:0] ucc_max_2,
    output logic        violation,
    output logic        in_ucc,
    output logic [1:0]  ucc_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_KILL
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [1:0]  r_cur_id;
    logic [1:0]  w_cur_id_nx;
    logic [15:0] r_prev_pc;

    logic [15:0] w_min [3];
    logic [15:0] w_max [3];
    logic [2:0]  w_pc_in;
    logic [2:0]  w_pc_at_min;
    logic [2:0]  w_data_in;
    logic [2:0]  w_dma_in;
    logic        w_pc_hit;
    logic        w_entry;
    logic [1:0]  w_entry_id;
    logic        w_wr_hit;
    logic        w_dma_hit;
    logic        w_pc_mid;
    logic        w_pc_other;
    logic [15:0] w_cur_max;

    assign w_min[0] = ucc_min_0;
    assign w_min[1] = ucc_min_1;
    assign w_min[2] = ucc_min_2;
    assign w_max[0] = ucc_max_0;
    assign w_max[1] = ucc_max_1;
    assign w_max[2] = ucc_max_2;

    // Inclusive membership; a region with min > max never matches.
    function automatic logic f_in_region(input logic [15:0] a,
                                         input logic [15:0] mn,
                                         input logic [15:0] mx);
        return (mn <= mx) && (a >= mn) && (a <= mx);
    endfunction

    always_comb begin
        w_pc_in     = '0;
        w_pc_at_min = '0;
        w_data_in   = '0;
        w_dma_in    = '0;
        w_pc_mid    = 1'b0;
        w_pc_other  = 1'b0;
        w_entry     = 1'b0;
        w_entry_id  = 2'b11;
        for (int unsigned i = 0; i < 3; i++) begin
            w_pc_in[i]     = f_in_region(pc, w_min[i], w_max[i]);
            w_pc_at_min[i] = w_pc_in[i] && (pc == w_min[i]);
            w_data_in[i]   = f_in_region(data_addr, w_min[i], w_max[i]);
            w_dma_in[i]    = f_in_region(dma_addr, w_min[i], w_max[i]);
            if (w_pc_in[i] && (pc != w_min[i]))
                w_pc_mid = 1'b1;
            if (w_pc_in[i] && (i[1:0] != r_cur_id))
                w_pc_other = 1'b1;
        end
        // Descending scan so the lowest matching index wins on overlap.
        for (int unsigned j = 3; j > 0; j--) begin
            if (w_pc_at_min[j-1]) begin
                w_entry    = 1'b1;
                w_entry_id = 2'(j - 1);
            end
        end
    end

    assign w_pc_hit  = |w_pc_in;
    assign w_wr_hit  = data_en && data_wr && (|w_data_in);
    assign w_dma_hit = dma_en && (|w_dma_in);

    always_comb begin
        case (r_cur_id)
            2'd0:    w_cur_max = w_max[0];
            2'd1:    w_cur_max = w_max[1];
            2'd2:    w_cur_max = w_max[2];
            default: w_cur_max = '0;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cur_id_nx = r_cur_id;
        case (r_state)
            S_IDLE: begin
                if (w_wr_hit || w_dma_hit || w_pc_mid) begin
                    w_state_nx = S_KILL;
                end else if (w_entry) begin
                    w_state_nx  = S_RUN;
                    w_cur_id_nx = w_entry_id;
                end
            end
            S_RUN: begin
                if (irq || w_wr_hit || w_dma_hit || w_pc_other ||
                    (!w_pc_hit && (r_prev_pc != w_cur_max))) begin
                    w_state_nx  = S_KILL;
                    w_cur_id_nx = 2'b11;
                end else if (!w_pc_hit) begin
                    // Leaving from the last address of the region is the only legal exit.
                    w_state_nx  = S_IDLE;
                    w_cur_id_nx = 2'b11;
                end
            end
            S_KILL: begin
                if (pc == RESET_PC)
                    w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx  = S_IDLE;
                w_cur_id_nx = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cur_id  <= 2'b11;
            r_prev_pc <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cur_id  <= w_cur_id_nx;
            r_prev_pc <= pc;
        end
    end

    assign violation = (r_state == S_KILL);
    assign in_ucc    = (r_state == S_RUN);
    assign ucc_id    = (r_state == S_RUN) ? r_cur_id : 2'b11;

endmodule

// File: tb/tb_ucc_monitor.sv
// Directed self-checking bench for ucc_monitor.
// Observed vector is {violation, in_ucc, ucc_id}:
//   4'b0011 idle, 4'b0100 run in region 0, 4'b0101 run in region 1,
//   4'b1011 violation.
module tb_ucc_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        irq;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        violation;
    logic        in_ucc;
    logic [1:0]  ucc_id;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [3:0]  obs;

    always #5 clk = ~clk;

    ucc_monitor #(.RESET_PC(16'hE000)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .irq       (irq),
        .data_en   (data_en),
        .data_wr   (data_wr),
        .data_addr (data_addr),
        .dma_en    (dma_en),
        .dma_addr  (dma_addr),
        .ucc_min_0 (16'hE100),
        .ucc_max_0 (16'hE1FF),
        .ucc_min_1 (16'hE200),
        .ucc_max_1 (16'hE2FF),
        .ucc_min_2 (16'hFFFF),
        .ucc_max_2 (16'h0000),
        .violation (violation),
        .in_ucc    (in_ucc),
        .ucc_id    (ucc_id)
    );

    // Inputs set before the call are sampled on the next edge; obs holds the
    // outputs that edge produced.
    task automatic step();
        @(posedge clk);
        #1;
        obs = {violation, in_ucc, ucc_id};
    endtask

    task automatic quiet();
        irq = 0; data_en = 0; data_wr = 0; data_addr = 16'h0000;
        dma_en = 0; dma_addr = 16'h0000;
    endtask

    task automatic do_reset();
        quiet();
        pc = 16'hC000;
        reset = 1; step();
        reset = 0;
    endtask

    task automatic test_reset();
        quiet();
        pc = 16'hC000;
        reset = 1; step(); step();
        reset = 0;
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL reset_state: got %b want %b", obs, 4'b0011); end
    endtask

    task automatic test_legal_run();
        do_reset();
        pc = 16'hC000; step();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL run_pre_idle: got %b want %b", obs, 4'b0011); end
        pc = 16'hE100; step();
        checks++; if (obs !== 4'b0100) begin errors++; $display("FAIL run_entry: got %b want %b", obs, 4'b0100); end
        pc = 16'hE150; step(); step(); step();
        checks++; if (obs !== 4'b0100) begin errors++; $display("FAIL run_pc_held: got %b want %b", obs, 4'b0100); end
        pc = 16'hE1FF; step();
        pc = 16'hE100; step();
        checks++; if (obs !== 4'b0100) begin errors++; $display("FAIL run_jump_to_min: got %b want %b", obs, 4'b0100); end
        pc = 16'hE1FF; step();
        checks++; if (obs !== 4'b0100) begin errors++; $display("FAIL run_at_max: got %b want %b", obs, 4'b0100); end
        pc = 16'hC010; step();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL run_legal_exit: got %b want %b", obs, 4'b0011); end
        data_en = 1; data_wr = 0; data_addr = 16'hE180;
        pc = 16'hE100; step();
        quiet();
        checks++; if (obs !== 4'b0100) begin errors++; $display("FAIL run_reentry_with_read: got %b want %b", obs, 4'b0100); end
    endtask

    task automatic test_mid_entry();
        do_reset();
        pc = 16'hC000; step();
        pc = 16'hE150; step();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL mid_entry_kill: got %b want %b", obs, 4'b1011); end
        pc = 16'hC000; step();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL kill_hold_c000: got %b want %b", obs, 4'b1011); end
        pc = 16'hE100; step();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL kill_hold_e100: got %b want %b", obs, 4'b1011); end
        pc = 16'hE000; step();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL kill_release: got %b want %b", obs, 4'b0011); end
        pc = 16'hE150; step();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL checks_resume: got %b want %b", obs, 4'b1011); end
    endtask

    task automatic test_illegal_exits();
        do_reset();
        pc = 16'hE200; step();
        checks++; if (obs !== 4'b0101) begin errors++; $display("FAIL r1_entry: got %b want %b", obs, 4'b0101); end
        pc = 16'hE210; irq = 1; step();
        irq = 0;
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL irq_in_ucc: got %b want %b", obs, 4'b1011); end

        do_reset();
        pc = 16'hE200; step();
        pc = 16'hE250; step();
        checks++; if (obs !== 4'b0101) begin errors++; $display("FAIL r1_inside: got %b want %b", obs, 4'b0101); end
        pc = 16'hC000; step();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL bad_exit: got %b want %b", obs, 4'b1011); end

        do_reset();
        pc = 16'hE200; step();
        pc = 16'hE250; step();
        pc = 16'hE120; step();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL cross_ucc: got %b want %b", obs, 4'b1011); end

        do_reset();
        pc = 16'hE200; step();
        pc = 16'hE250; dma_en = 1; dma_addr = 16'hE1AA; step();
        quiet();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL dma_in_run: got %b want %b", obs, 4'b1011); end
    endtask

    task automatic test_memory_protection();
        do_reset();
        pc = 16'hC000; data_en = 1; data_wr = 1; data_addr = 16'hE180; step();
        quiet();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL write_hit: got %b want %b", obs, 4'b1011); end

        do_reset();
        pc = 16'hC000; dma_en = 1; dma_addr = 16'hE2AA; step();
        quiet();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL dma_hit: got %b want %b", obs, 4'b1011); end

        do_reset();
        pc = 16'hC000; data_en = 1; data_wr = 0; data_addr = 16'hE180; step();
        quiet();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL read_legal: got %b want %b", obs, 4'b0011); end
        pc = 16'hC000; data_en = 0; data_wr = 1; data_addr = 16'hE180; step();
        quiet();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL unqualified_write: got %b want %b", obs, 4'b0011); end
    endtask

    task automatic test_disabled_region();
        do_reset();
        pc = 16'h0000; step();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL disabled_pc0000: got %b want %b", obs, 4'b0011); end
        pc = 16'hFFFF; step();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL disabled_pcffff: got %b want %b", obs, 4'b0011); end
        pc = 16'hC000; data_en = 1; data_wr = 1; data_addr = 16'h0000; step();
        quiet();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL disabled_write: got %b want %b", obs, 4'b0011); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        pc = 16'hE150; step();
        checks++; if (obs !== 4'b1011) begin errors++; $display("FAIL rst_pre_kill: got %b want %b", obs, 4'b1011); end
        reset = 1; pc = 16'hC000; step();
        reset = 0;
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL rst_from_kill: got %b want %b", obs, 4'b0011); end
        pc = 16'hE200; step();
        checks++; if (obs !== 4'b0101) begin errors++; $display("FAIL entry_after_kill_rst: got %b want %b", obs, 4'b0101); end
        pc = 16'hE210; reset = 1; step();
        reset = 0;
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL rst_from_run: got %b want %b", obs, 4'b0011); end
        // The bench holds pc at 0xE210 through the reset edge. Afterwards the
        // monitor is idle again, so a mid-region pc is treated as a breach.
        pc = 16'hE200; step();
        checks++; if (obs !== 4'b0101) begin errors++; $display("FAIL entry_after_run_rst: got %b want %b", obs, 4'b0101); end
        pc = 16'hE2FF; step();
        pc = 16'hC000; step();
        checks++; if (obs !== 4'b0011) begin errors++; $display("FAIL exit_after_rst: got %b want %b", obs, 4'b0011); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        quiet();
        pc = 16'hC000;
        reset = 1;
        test_reset();
        test_legal_run();
        test_mid_entry();
        test_illegal_exits();
        test_memory_protection();
        test_disabled_region();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
